// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and helpers for the RAM port arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default RAM geometry (32b x 64)
//   NUM_REQ_DEF             : default number of requesters
//   MAX_NUM_REQ             : largest supported requester count
//   MAX_LOCK_DEF            : default burst lock limit
//   idx_w()                 : index width for n items, never below one bit
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF   = 6;
    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned NUM_REQ_DEF  = 4;
    localparam int unsigned MAX_NUM_REQ  = 8;
    localparam int unsigned MAX_LOCK_DEF = 8;

    // Bits needed to index n items; at least one so vectors never collapse.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and RAM-side signals for the arbiter.
//   req_*   : per-requester commands, addresses/data packed at [i*W +: W]
//   req_ready_o / rsp_* : one-hot grant, one-hot read response + shared data
//   mem_*   : RAM macro command side, mem_rdata_i is its registered output
// Modports: slave = arbiter, master = clients plus RAM macro.
interface mem_port_arbiter_if #(
    parameter int unsigned NUM_REQ = mem_arb_pkg::NUM_REQ_DEF,
    parameter int unsigned ADDR_W  = mem_arb_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W  = mem_arb_pkg::DATA_W_DEF
) ();

    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_we_i;
    logic [NUM_REQ-1:0]        req_lock_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ-1:0]        rsp_valid_o;
    logic [DATA_W-1:0]         rsp_data_o;
    logic                      mem_we_o;
    logic [ADDR_W-1:0]         mem_addr_o;
    logic [DATA_W-1:0]         mem_wdata_o;
    logic [DATA_W-1:0]         mem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_lock_i, req_addr_i, req_wdata_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_lock_i, req_addr_i, req_wdata_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i : request vector
//   ptr_i : highest-priority index this cycle
//   gnt_o : one-hot grant of first request at/after ptr_i (wrapping)
//   idx_o : index of that grant
//   any_o : at least one request present
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;

    // Scan from the pointer upward, first hit wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = IDX_W'((32'(ptr_i) + off) % NUM_REQ);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between NUM_REQ requesters.
// Round-robin grant with an optional bounded burst lock; read data from the
// RAM's registered output is routed back to the issuing requester one cycle
// after acceptance.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : requester commands/grants/responses and RAM command side
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned      IDX_W    = idx_w(NUM_REQ);
    localparam int unsigned      CNT_W    = idx_w(MAX_LOCK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               lock_act_q, lock_act_d;
    logic [IDX_W-1:0]   lock_own_q, lock_own_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rsp_vld_q, rsp_vld_d;
    logic [IDX_W-1:0]   rsp_idx_q, rsp_idx_d;

    logic [NUM_REQ-1:0] rr_gnt;
    logic [IDX_W-1:0]   rr_idx;
    logic               rr_any;
    logic               forced;
    logic [IDX_W-1:0]   win_idx;
    logic               win_we;
    logic               win_lock;
    logic [CNT_W-1:0]   run_cnt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i (bus.req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx),
        .any_o (rr_any)
    );

    // A held lock only overrides round-robin while its owner is still asking.
    assign forced  = lock_act_q && bus.req_valid_i[lock_own_q];
    assign win_idx = forced ? lock_own_q : rr_idx;

    // Grant and RAM command mux; everything quiet when nobody is valid.
    always_comb begin
        bus.req_ready_o = '0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        win_we          = 1'b0;
        win_lock        = 1'b0;
        if (rr_any) begin
            bus.req_ready_o = forced ? (NUM_REQ'(1) << lock_own_q) : rr_gnt;
            win_we          = bus.req_we_i[win_idx];
            win_lock        = bus.req_lock_i[win_idx];
            bus.mem_we_o    = win_we;
            bus.mem_addr_o  = bus.req_addr_i[32'(win_idx)*ADDR_W +: ADDR_W];
            bus.mem_wdata_o = bus.req_wdata_i[32'(win_idx)*DATA_W +: DATA_W];
        end
    end

    // Pointer, lock and response-tag next state.
    always_comb begin
        ptr_d      = ptr_q;
        lock_act_d = 1'b0;
        lock_own_d = lock_own_q;
        cnt_d      = '0;
        rsp_vld_d  = 1'b0;
        rsp_idx_d  = rsp_idx_q;
        // Grants already taken in the current burst; a fresh winner starts at zero.
        run_cnt    = forced ? cnt_q : '0;
        if (rr_any) begin
            rsp_vld_d = !win_we;
            rsp_idx_d = win_idx;
            if (win_lock && (run_cnt < CNT_LAST)) begin
                lock_act_d = 1'b1;
                lock_own_d = win_idx;
                cnt_d      = run_cnt + 1'b1;
            end else begin
                ptr_d = (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_act_q <= 1'b0;
            lock_own_q <= '0;
            cnt_q      <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_idx_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_act_q <= lock_act_d;
            lock_own_q <= lock_own_d;
            cnt_q      <= cnt_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_idx_q  <= rsp_idx_d;
        end
    end

    // Response steering: RAM read data passes straight through to the tagged requester.
    assign bus.rsp_valid_o = rsp_vld_q ? (NUM_REQ'(1) << rsp_idx_q) : '0;
    assign bus.rsp_data_o  = bus.mem_rdata_i;

endmodule
